// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Decode-stage hazard detection and operand forwarding for the RV32I pipeline.
// Every in-flight register write is tracked in a pending-register scoreboard.
// Each decode source operand is bypassed from the result broadcast when the
// broadcast targets its register. Decode is stalled while any used source is
// still waiting for its producer. Sits between the register file read ports
// and the D/E pipeline register.
//
// Parameters
//   XLEN  operand/result width
//   NREG  number of architectural registers (register 0 reads as zero)
//   RAW   register address width, 2**RAW must equal NREG
//   NSRC  number of decode source operand ports
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   issue_valid     instruction leaves D for E this cycle
//   issue_wen       issuing instruction writes a register
//   issue_load      issuing instruction is a load
//   issue_rd        destination of the issuing instruction
//   src_used        per-operand "operand is read" flags
//   src_addr        packed source addresses, operand i at [i*RAW +: RAW]
//   src_rf_data     packed register file read data, operand i at [i*XLEN +: XLEN]
//   res_valid       result broadcast valid (ALU result or load data)
//   res_rd          broadcast destination register
//   res_data        broadcast value
//   flush           redirect; kills every in-flight producer
//   src_data        packed forwarded operands
//   stall           hold D and F, insert a bubble into E
//   load_use        stall is caused at least partly by a pending load
//   pending_mask    registered scoreboard, bit r set while r awaits its result
//   stall_cycles    (HAZARD_PERF_EN only) cycles with stall = 1, wraps
//   load_use_cycles (HAZARD_PERF_EN only) cycles with load_use = 1, wraps
//
// Build option
//   HAZARD_PERF_EN  when defined, adds the two 32-bit performance counters.
//                   Functional behaviour is the same in both builds.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RAW  = 5,
    parameter int NSRC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue_valid,
    input  logic                   issue_wen,
    input  logic                   issue_load,
    input  logic [RAW-1:0]         issue_rd,
    input  logic [NSRC-1:0]        src_used,
    input  logic [NSRC*RAW-1:0]    src_addr,
    input  logic [NSRC*XLEN-1:0]   src_rf_data,
    input  logic                   res_valid,
    input  logic [RAW-1:0]         res_rd,
    input  logic [XLEN-1:0]        res_data,
    input  logic                   flush,
    output logic [NSRC*XLEN-1:0]   src_data,
    output logic                   stall,
    output logic                   load_use,
`ifdef HAZARD_PERF_EN
    output logic [31:0]            stall_cycles,
    output logic [31:0]            load_use_cycles,
`endif
    output logic [NREG-1:0]        pending_mask
);

    // Scoreboard state. Bit 0 of both vectors is forced to zero on every
    // update so register 0 can never appear pending.
    logic [NREG-1:0] pending;
    logic [NREG-1:0] is_load;
    logic [NREG-1:0] pending_nxt;
    logic [NREG-1:0] is_load_nxt;

    logic [NSRC-1:0] hit;
    logic [NSRC-1:0] blocked;
    logic [NSRC-1:0] blocked_load;

    logic issue_accept;
    logic issue_set;
    logic res_clear;

    // -------------------------------------------------------------------------
    // Per-operand forwarding and hazard detection
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [RAW-1:0] addr;

        assign addr = src_addr[i*RAW +: RAW];

        // A broadcast to register 0 is never a bypass source.
        assign hit[i] = res_valid && (res_rd == addr) && (addr != '0);

        // Unused operands are still forwarded; the D stage decides whether
        // the value matters.
        assign src_data[i*XLEN +: XLEN] = hit[i]         ? res_data :
                                          (addr == '0)   ? '0       :
                                          src_rf_data[i*XLEN +: XLEN];

        // The result arriving this cycle releases the operand immediately,
        // so a broadcast hit never blocks.
        assign blocked[i]      = src_used[i] && pending[addr] && !hit[i];
        assign blocked_load[i] = blocked[i] && is_load[addr];
    end

    assign stall    = |blocked;
    assign load_use = |blocked_load;

    // -------------------------------------------------------------------------
    // Scoreboard next state
    // -------------------------------------------------------------------------
    // An issue during a stall is a protocol error and is dropped. An issue in
    // a flush cycle is a killed instruction and is dropped as well.
    assign issue_accept = issue_valid && !stall && !flush;
    assign issue_set    = issue_accept && issue_wen && (issue_rd != '0);
    assign res_clear    = res_valid && (res_rd != '0);

    always_comb begin
        pending_nxt = pending;
        is_load_nxt = is_load;

        if (flush) begin
            pending_nxt = '0;
            is_load_nxt = '0;
        end else begin
            // Clear first, then set: when the same register is both retired
            // and re-issued in one cycle the new producer must stay tracked.
            if (res_clear) begin
                pending_nxt[res_rd] = 1'b0;
                is_load_nxt[res_rd] = 1'b0;
            end
            if (issue_set) begin
                pending_nxt[issue_rd] = 1'b1;
                is_load_nxt[issue_rd] = issue_load;
            end
        end

        pending_nxt[0] = 1'b0;
        is_load_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            is_load <= '0;
        end else begin
            pending <= pending_nxt;
            is_load <= is_load_nxt;
        end
    end

    assign pending_mask = pending;

    // -------------------------------------------------------------------------
    // Optional performance counters, free-running and wrapping at 2**32
    // -------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] load_use_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt    <= '0;
            load_use_cnt <= '0;
        end else begin
            if (stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (load_use) begin
                load_use_cnt <= load_use_cnt + 32'd1;
            end
        end
    end

    assign stall_cycles    = stall_cnt;
    assign load_use_cycles = load_use_cnt;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RAW  = 5;
    localparam int NSRC = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 issue_valid;
    logic                 issue_wen;
    logic                 issue_load;
    logic [RAW-1:0]       issue_rd;
    logic [NSRC-1:0]      src_used;
    logic [NSRC*RAW-1:0]  src_addr;
    logic [NSRC*XLEN-1:0] src_rf_data;
    logic                 res_valid;
    logic [RAW-1:0]       res_rd;
    logic [XLEN-1:0]      res_data;
    logic                 flush;
    logic [NSRC*XLEN-1:0] src_data;
    logic                 stall;
    logic                 load_use;
    logic [NREG-1:0]      pending_mask;
`ifdef HAZARD_PERF_EN
    logic [31:0]          stall_cycles;
    logic [31:0]          load_use_cycles;
`endif

    hazard_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .RAW(RAW), .NSRC(NSRC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_wen      (issue_wen),
        .issue_load     (issue_load),
        .issue_rd       (issue_rd),
        .src_used       (src_used),
        .src_addr       (src_addr),
        .src_rf_data    (src_rf_data),
        .res_valid      (res_valid),
        .res_rd         (res_rd),
        .res_data       (res_data),
        .flush          (flush),
        .src_data       (src_data),
        .stall          (stall),
        .load_use       (load_use),
`ifdef HAZARD_PERF_EN
        .stall_cycles   (stall_cycles),
        .load_use_cycles(load_use_cycles),
`endif
        .pending_mask   (pending_mask)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Reference model: a set of registers awaiting a result, each tagged with
    // whether its producer is a load, plus cycle tallies.
    bit          mp[NREG];
    bit          ml[NREG];
    int unsigned m_sc;
    int unsigned m_lc;

    typedef struct {
        logic        iv, iw, il;
        logic [4:0]  ird;
        logic [1:0]  used;
        logic [4:0]  a0, a1;
        logic [31:0] rf0, rf1;
        logic        rv;
        logic [4:0]  rrd;
        logic [31:0] rdat;
        logic        fl;
        logic        e_st, e_lu;
        logic [31:0] e_d0, e_d1, e_pm;
    } vec_t;

    localparam int NTBL = 18;
    vec_t tbl[NTBL];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_idle();
        issue_valid = 1'b0; issue_wen = 1'b0; issue_load = 1'b0; issue_rd = '0;
        src_used = '0; src_addr = '0; src_rf_data = '0;
        res_valid = 1'b0; res_rd = '0; res_data = '0; flush = 1'b0;
    endtask

    function automatic void model_eval(output bit st, output bit lu, output logic [63:0] d);
        st = 1'b0; lu = 1'b0; d = '0;
        for (int i = 0; i < NSRC; i++) begin
            int a;
            bit hit;
            a   = int'(src_addr[i*RAW +: RAW]);
            hit = res_valid && (int'(res_rd) == a) && (a != 0);
            if (hit)         d[i*XLEN +: XLEN] = res_data;
            else if (a != 0) d[i*XLEN +: XLEN] = src_rf_data[i*XLEN +: XLEN];
            if (src_used[i] && mp[a] && !hit) begin
                st = 1'b1;
                if (ml[a]) lu = 1'b1;
            end
        end
    endfunction

    function automatic logic [NREG-1:0] model_mask();
        logic [NREG-1:0] m;
        m = '0;
        for (int r = 0; r < NREG; r++) m[r] = mp[r];
        return m;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) begin
            mp[r] = 1'b0;
            ml[r] = 1'b0;
        end
    endtask

    // Applies the current inputs to the model at a rising edge.
    task automatic model_edge(input bit st, input bit lu);
        int rd;
        if (!rst_n) begin
            model_clear();
            m_sc = 0;
            m_lc = 0;
        end else begin
            if (st) m_sc++;
            if (lu) m_lc++;
            if (flush) begin
                model_clear();
            end else begin
                if (res_valid && res_rd != 0) begin
                    rd = int'(res_rd);
                    mp[rd] = 1'b0;
                    ml[rd] = 1'b0;
                end
                if (issue_valid && !st && issue_wen && issue_rd != 0) begin
                    rd = int'(issue_rd);
                    mp[rd] = 1'b1;
                    ml[rd] = issue_load;
                end
            end
        end
    endtask

    // Inputs are already applied; compare outputs against the model, then clock.
    task automatic cycle_check(input string tag);
        bit st, lu;
        logic [63:0] d;
        #2;
        model_eval(st, lu, d);
        chk({tag, " stall"},        64'(stall),        64'(st));
        chk({tag, " load_use"},     64'(load_use),     64'(lu));
        chk({tag, " src_data"},     64'(src_data),     d);
        chk({tag, " pending_mask"}, 64'(pending_mask), 64'(model_mask()));
`ifdef HAZARD_PERF_EN
        chk({tag, " stall_cycles"},    64'(stall_cycles),    64'(m_sc));
        chk({tag, " load_use_cycles"}, 64'(load_use_cycles), 64'(m_lc));
`endif
        @(posedge clk);
        model_edge(st, lu);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        set_idle();
        src_used = 2'b11;
        src_addr = {5'd2, 5'd1};
        @(posedge clk);
        model_edge(1'b0, 1'b0);
        #1;
        chk({tag, " pending_mask"}, 64'(pending_mask), 64'd0);
        chk({tag, " stall"},        64'(stall),        64'd0);
        chk({tag, " load_use"},     64'(load_use),     64'd0);
`ifdef HAZARD_PERF_EN
        chk({tag, " stall_cycles"},    64'(stall_cycles),    64'd0);
        chk({tag, " load_use_cycles"}, 64'(load_use_cycles), 64'd0);
`endif
        rst_n = 1'b1;
    endtask

    initial begin
        //         iv iw il ird used a0 a1  rf0      rf1     rv rrd rdat     fl  st lu d0       d1     pm
        tbl[0]  = '{0, 0, 0, 0,  3,  1, 2, 'h11,    'h22,   0, 0,  0,       0,  0, 0, 'h11,    'h22,  0};
        tbl[1]  = '{1, 1, 1, 5,  3,  1, 2, 'h11,    'h22,   0, 0,  0,       0,  0, 0, 'h11,    'h22,  0};
        tbl[2]  = '{0, 0, 0, 0,  1,  5, 0, 'h55,    'h99,   0, 0,  0,       0,  1, 1, 'h55,    0,     'h20};
        tbl[3]  = '{0, 0, 0, 0,  1,  5, 0, 'h55,    'h99,   0, 0,  0,       0,  1, 1, 'h55,    0,     'h20};
        tbl[4]  = '{1, 0, 0, 0,  1,  5, 0, 'h55,    'h99,   1, 5,  'hDEAD,  0,  0, 0, 'hDEAD,  0,     'h20};
        tbl[5]  = '{1, 1, 0, 0,  1,  0, 0, 'hFFFF,  'hFFFF, 0, 0,  0,       0,  0, 0, 0,       0,     0};
        tbl[6]  = '{1, 1, 0, 7,  1,  0, 0, 'hFFFF,  0,      1, 7,  1,       0,  0, 0, 0,       0,     0};
        tbl[7]  = '{1, 1, 0, 9,  1,  7, 0, 'h77,    0,      0, 0,  0,       0,  1, 0, 'h77,    0,     'h80};
        tbl[8]  = '{1, 1, 0, 3,  1,  7, 0, 'h77,    0,      1, 7,  2,       0,  0, 0, 2,       0,     'h80};
        tbl[9]  = '{1, 1, 0, 9,  0,  3, 0, 'h33,    0,      0, 0,  0,       0,  0, 0, 'h33,    0,     'h08};
        tbl[10] = '{1, 1, 1, 4,  0,  0, 0, 0,       0,      0, 0,  0,       1,  0, 0, 0,       0,     'h208};
        tbl[11] = '{0, 0, 0, 0,  1,  4, 0, 'h44,    0,      0, 0,  0,       0,  0, 0, 'h44,    0,     0};
        tbl[12] = '{1, 1, 0, 6,  2,  0, 2, 0,       'h22,   0, 0,  0,       0,  0, 0, 0,       'h22,  0};
        tbl[13] = '{0, 0, 0, 0,  2,  6, 6, 'h60,    'h66,   0, 0,  0,       0,  1, 0, 'h60,    'h66,  'h40};
        tbl[14] = '{0, 0, 0, 0,  3,  0, 6, 'h5,     'h66,   1, 0,  'hBAD,   0,  1, 0, 0,       'h66,  'h40};
        tbl[15] = '{1, 1, 0, 8,  2,  0, 6, 0,       'h66,   0, 0,  0,       1,  1, 0, 0,       'h66,  'h40};
        tbl[16] = '{0, 0, 0, 0,  2,  0, 6, 0,       'h66,   0, 0,  0,       0,  0, 0, 0,       'h66,  0};
        tbl[17] = '{0, 0, 0, 0,  2,  0, 12, 0,      'hC0,   1, 12, 'h1234,  0,  0, 0, 0,       'h1234, 0};

        model_clear();
        m_sc = 0;
        m_lc = 0;
        set_idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset("reset0");

        // Directed table: state carries from one row to the next.
        for (int k = 0; k < NTBL; k++) begin
            bit st, lu;
            logic [63:0] d;
            string tag;
            tag = $sformatf("tbl%0d", k);
            issue_valid = tbl[k].iv; issue_wen = tbl[k].iw; issue_load = tbl[k].il;
            issue_rd = tbl[k].ird; src_used = tbl[k].used;
            src_addr = {tbl[k].a1, tbl[k].a0};
            src_rf_data = {tbl[k].rf1, tbl[k].rf0};
            res_valid = tbl[k].rv; res_rd = tbl[k].rrd; res_data = tbl[k].rdat;
            flush = tbl[k].fl;
            #2;
            chk({tag, " stall"},        64'(stall),        64'(tbl[k].e_st));
            chk({tag, " load_use"},     64'(load_use),     64'(tbl[k].e_lu));
            chk({tag, " src_data"},     64'(src_data),     {tbl[k].e_d1, tbl[k].e_d0});
            chk({tag, " pending_mask"}, 64'(pending_mask), 64'(tbl[k].e_pm));
            model_eval(st, lu, d);
            @(posedge clk);
            model_edge(st, lu);
            #1;
        end

        // Load-use then ALU dependency, counted from a fresh reset.
        do_reset("reset1");
        set_idle();
        issue_valid = 1'b1; issue_wen = 1'b1; issue_load = 1'b1; issue_rd = 5'd5;
        cycle_check("seq_ld_issue");
        set_idle();
        src_used = 2'b01; src_addr = {5'd0, 5'd5};
        for (int n = 0; n < 3; n++) begin
            #2;
            chk("seq_ld stall", 64'(stall), 64'd1);
            cycle_check("seq_ld_wait");
        end
        res_valid = 1'b1; res_rd = 5'd5; res_data = 32'hDEAD;
        issue_valid = 1'b1; issue_wen = 1'b1; issue_rd = 5'd6;
        #2;
        chk("seq_ld operand", 64'(src_data[31:0]), 64'h0000_DEAD);
        cycle_check("seq_ld_done");
        set_idle();
        src_used = 2'b10; src_addr = {5'd6, 5'd0};
        repeat (2) cycle_check("seq_alu_wait");
        res_valid = 1'b1; res_rd = 5'd6; res_data = 32'h6;
        cycle_check("seq_alu_done");
`ifdef HAZARD_PERF_EN
        chk("perf stall_cycles",    64'(stall_cycles),    64'd5);
        chk("perf load_use_cycles", 64'(load_use_cycles), 64'd3);
`endif

        // Randomised traffic on a small register window to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            issue_valid = 1'($urandom_range(0, 1));
            issue_wen   = 1'($urandom_range(0, 3) != 0);
            issue_load  = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 7));
            src_used    = 2'($urandom_range(0, 3));
            src_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            src_rf_data = {$urandom, $urandom};
            res_valid   = 1'($urandom_range(0, 1));
            res_rd      = 5'($urandom_range(0, 7));
            res_data    = $urandom;
            flush       = 1'($urandom_range(0, 19) == 0);
            cycle_check("rnd");
        end

        // Build up pending state, then reset must wipe it.
        set_idle();
        issue_valid = 1'b1; issue_wen = 1'b1; issue_load = 1'b1; issue_rd = 5'd1;
        cycle_check("pre_reset_issue");
        set_idle();
        #2;
        chk("pre_reset pending", 64'(pending_mask[1]), 64'd1);
        do_reset("reset2");
        set_idle();
        cycle_check("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
